draw_ball: RTL and testbench
============================

// Module: draw_ball
// PURPOSE
//  Pixel-pipeline stage directly downstream of the background stage in the PONG video chain.
//  Keeps the ball position and moves it once per frame, with wall bounce, a serve and a miss FSM.
//  Overlays the ball on the incoming rgb stream.
//  Forwards all timing signals with the same 1-cycle latency as every other draw stage.
// PARAMETERS
//  H_ACTIVE    1024      visible pixels per line
//  V_ACTIVE    768       visible lines per frame
//  BALL_SIZE   16        ball edge length, px
//  SPEED       4         px moved per frame on each axis
//  BALL_COLOR  12'hf_f_f ball rgb
// PORTS
//  pclk         in   1   pixel clock
//  rst          in   1   reset; synchronous, active-high
//  hcount_in    in   11  horizontal pixel count
//  vcount_in    in   11  vertical line count
//  hsync_in     in   1   horizontal sync
//  vsync_in     in   1   vertical sync
//  hblnk_in     in   1   horizontal blanking
//  vblnk_in     in   1   vertical blanking
//  rgb_in       in   12  colour from the upstream (background) stage
//  serve        in   1   launch ball; honoured only in IDLE
//  serve_dir    in   1   launch direction: 0 = left, 1 = right
//  bounce_x     in   1   paddle-hit pulse; reverses horizontal direction
//  *_out        out  -   hcount/vcount/hsync/vsync/hblnk/vblnk delayed by 1 pclk
//  rgb_out      out  12  composited colour
//  ball_x       out  11  ball top-left x
//  ball_y       out  11  ball top-left y
//  miss_left    out  1   1-cycle pulse: ball exited the left edge
//  miss_right   out  1   1-cycle pulse: ball exited the right edge
// BEHAVIOUR
//  Reset values
//   - All *_out, rgb_out and miss_* are 0.
//   - ball_x = (H_ACTIVE-BALL_SIZE)/2 = 504; ball_y = (V_ACTIVE-BALL_SIZE)/2 = 376.
//   - dir_x = right; dir_y = down; state = IDLE; bounce latch cleared.
//  Frame tick
//   - tick = vblnk_in & ~vblnk_q, where vblnk_q is vblnk_in registered.
//   - Position updates only on the pclk edge where tick = 1.
//  FSM
//   - IDLE: ball held at centre. When serve = 1 on any cycle: dir_x <= serve_dir, dir_y <= down,
//     go to MOVE. Movement starts at the next tick.
//   - MOVE: on each tick, apply the move rules below. serve is ignored.
//   - MISS: lasts exactly 1 cycle. Ball recentred, miss_* deasserted, go to IDLE.
//  Move rules (all 11-bit unsigned, no wrap)
//   - Bounce latch: set by bounce_x on any cycle; cleared on tick. If set at the tick,
//     dir_x is flipped before the step is applied.
//   - Y moving down: if y+SPEED >= V_ACTIVE-BALL_SIZE then y <= V_ACTIVE-BALL_SIZE and dir_y <= up;
//     else y <= y+SPEED.
//   - Y moving up: if y < SPEED then y <= 0 and dir_y <= down; else y <= y-SPEED.
//   - X moving right: if x+SPEED >= H_ACTIVE-BALL_SIZE then miss_right <= 1 and go to MISS;
//     else x <= x+SPEED.
//   - X moving left: if x < SPEED then miss_left <= 1 and go to MISS; else x <= x-SPEED.
//   - A bounce and an edge reached on the same tick: the bounce wins and no miss is raised.
//  Pixel path (latency 1)
//   - hit = !hblnk_in & !vblnk_in & x <= hcount_in < x+BALL_SIZE & y <= vcount_in < y+BALL_SIZE.
//   - rgb_out <= hit ? BALL_COLOR : rgb_in.
//   - Blanking passes rgb_in through unchanged.
//  rst asserted mid-frame or mid-move: all state returns to reset values on the next edge.
// CONFIGURATION
//  DRAW_BALL_ROUND_EN
//   - Defined: hit also requires (2dx-BALL_SIZE+1)^2 + (2dy-BALL_SIZE+1)^2 <= BALL_SIZE^2,
//     where dx = hcount_in-x and dy = vcount_in-y. This draws a disc; latency stays 1.
//   - Undefined: square ball, no multipliers instantiated.
// STRUCTURE
//  pong_pkg
//   - H_ACTIVE/V_ACTIVE constants, colour constants, ball FSM state encoding (IDLE/MOVE/MISS).
//  Sub-module ball_motion
//   - Contains tick detect, FSM, position/direction registers and miss pulses.
//   - draw_ball keeps the timing pipeline and the overlay compare.
// TESTING
//  1. rst held 3 cycles -> ball_x=504, ball_y=376, rgb_out=0, miss_*=0.
//  2. IDLE, no serve, 3 frames -> position unchanged; rgb_out=fff at (504..519, 376..391), else rgb_in.
//  3. serve=1, serve_dir=1 -> after 1st tick x=508, y=380; after 2nd tick x=512, y=384.
//  4. Set y=750, moving down -> next tick y=752, dir up; following tick y=748.
//  5. Move right from x=1004 -> tick raises miss_right for 1 cycle; next cycle x=504, IDLE.
//     Repeat with bounce_x pulsed before the tick -> x=1000, no miss.
//  6. rgb_in=0f0 during hblnk at the ball row -> rgb_out=0f0. Check all *_out lag *_in by exactly 1 pclk.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants, typedefs and ball FSM encoding for the PONG video chain.
package pong_pkg;

    typedef logic [10:0] coord_t;
    typedef logic [11:0] rgb_t;

    localparam int   H_ACTIVE   = 1024;
    localparam int   V_ACTIVE   = 768;
    localparam int   BALL_SIZE  = 16;
    localparam int   SPEED      = 4;
    localparam rgb_t BALL_COLOR = 12'hfff;
    localparam rgb_t RGB_BLACK  = 12'h000;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MOVE = 2'd1;
    localparam logic [1:0] MISS = 2'd2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/draw_ball_if.sv
// Video timing + colour bundle passed between draw stages.
interface draw_ball_if;
    import pong_pkg::*;

    coord_t hcount;
    coord_t vcount;
    logic   hsync;
    logic   vsync;
    logic   hblnk;
    logic   vblnk;
    rgb_t   rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/draw_ball_motion.sv
// Ball position keeper: frame tick detect, serve/move/miss FSM, wall bounce and miss pulses.
module ball_motion #(
    parameter int H_ACTIVE  = pong_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = pong_pkg::V_ACTIVE,
    parameter int BALL_SIZE = pong_pkg::BALL_SIZE,
    parameter int SPEED     = pong_pkg::SPEED
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        serve,
    input  logic        serve_dir,
    input  logic        bounce_x,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        miss_left,
    output logic        miss_right
);
    import pong_pkg::*;

    localparam logic [10:0] X_CENTRE = 11'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] Y_CENTRE = 11'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [11:0] X_MAX    = 12'(H_ACTIVE - BALL_SIZE);
    localparam logic [11:0] Y_MAX    = 12'(V_ACTIVE - BALL_SIZE);
    localparam logic [11:0] STEP     = 12'(SPEED);

    logic [1:0]  state;
    logic        vblnk_q;
    logic        tick;
    logic        bounce_q;
    logic        bounce_now;
    logic        dir_x;
    logic        dir_y;
    logic        dir_x_eff;
    logic        dir_y_next;
    logic        edge_hit;
    logic [10:0] x_next;
    logic [10:0] y_next;

    assign tick       = vblnk & ~vblnk_q;
    assign bounce_now = bounce_q | bounce_x;
    assign dir_x_eff  = bounce_now ? ~dir_x : dir_x;

    always_comb begin
        y_next     = ball_y;
        dir_y_next = dir_y;
        if (dir_y == DIR_DOWN) begin
            if ({1'b0, ball_y} + STEP >= Y_MAX) begin
                y_next     = Y_MAX[10:0];
                dir_y_next = DIR_UP;
            end else begin
                y_next = ball_y + STEP[10:0];
            end
        end else begin
            if ({1'b0, ball_y} < STEP) begin
                y_next     = '0;
                dir_y_next = DIR_DOWN;
            end else begin
                y_next = ball_y - STEP[10:0];
            end
        end
    end

    // An edge reached right after a bounce clamps to the wall instead of missing.
    always_comb begin
        x_next   = ball_x;
        edge_hit = 1'b0;
        if (dir_x_eff == DIR_RIGHT) begin
            if ({1'b0, ball_x} + STEP >= X_MAX) begin
                edge_hit = 1'b1;
                x_next   = X_MAX[10:0];
            end else begin
                x_next = ball_x + STEP[10:0];
            end
        end else begin
            if ({1'b0, ball_x} < STEP) begin
                edge_hit = 1'b1;
                x_next   = '0;
            end else begin
                x_next = ball_x - STEP[10:0];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_q    <= 1'b0;
            bounce_q   <= 1'b0;
            state      <= IDLE;
            dir_x      <= DIR_RIGHT;
            dir_y      <= DIR_DOWN;
            ball_x     <= X_CENTRE;
            ball_y     <= Y_CENTRE;
            miss_left  <= 1'b0;
            miss_right <= 1'b0;
        end else begin
            vblnk_q <= vblnk;
            if (tick) begin
                bounce_q <= 1'b0;
            end else if (bounce_x) begin
                bounce_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    ball_x <= X_CENTRE;
                    ball_y <= Y_CENTRE;
                    if (serve) begin
                        dir_x <= serve_dir;
                        dir_y <= DIR_DOWN;
                        state <= MOVE;
                    end
                end
                MOVE: begin
                    if (tick) begin
                        dir_x  <= dir_x_eff;
                        dir_y  <= dir_y_next;
                        ball_y <= y_next;
                        if (edge_hit && !bounce_now) begin
                            miss_right <= (dir_x_eff == DIR_RIGHT);
                            miss_left  <= (dir_x_eff == DIR_LEFT);
                            state      <= MISS;
                        end else begin
                            ball_x <= x_next;
                        end
                    end
                end
                MISS: begin
                    ball_x     <= X_CENTRE;
                    ball_y     <= Y_CENTRE;
                    miss_left  <= 1'b0;
                    miss_right <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/draw_ball.sv
// PONG draw stage: overlays the ball on the background stream with 1-cycle latency.
// Optional DRAW_BALL_ROUND_EN draws a disc instead of a square.
module draw_ball #(
    parameter int          H_ACTIVE   = pong_pkg::H_ACTIVE,
    parameter int          V_ACTIVE   = pong_pkg::V_ACTIVE,
    parameter int          BALL_SIZE  = pong_pkg::BALL_SIZE,
    parameter int          SPEED      = pong_pkg::SPEED,
    parameter logic [11:0] BALL_COLOR = pong_pkg::BALL_COLOR
) (
    input  logic              pclk,
    input  logic              rst,
    draw_ball_if.slave        bg,
    draw_ball_if.master       disp,
    input  logic              serve,
    input  logic              serve_dir,
    input  logic              bounce_x,
    output logic [10:0]       ball_x,
    output logic [10:0]       ball_y,
    output logic              miss_left,
    output logic              miss_right
);
    import pong_pkg::*;

    coord_t      hcount_p1;
    coord_t      vcount_p1;
    logic        hsync_p1;
    logic        vsync_p1;
    logic        hblnk_p1;
    logic        vblnk_p1;
    rgb_t        rgb_p1;
    logic [11:0] x_end;
    logic [11:0] y_end;
    logic        in_x;
    logic        in_y;
    logic        in_disc;
    logic        hit;

    ball_motion #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .BALL_SIZE (BALL_SIZE),
        .SPEED     (SPEED)
    ) u_motion (
        .pclk       (pclk),
        .rst        (rst),
        .vblnk      (bg.vblnk),
        .serve      (serve),
        .serve_dir  (serve_dir),
        .bounce_x   (bounce_x),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .miss_left  (miss_left),
        .miss_right (miss_right)
    );

    assign x_end = {1'b0, ball_x} + 12'(BALL_SIZE);
    assign y_end = {1'b0, ball_y} + 12'(BALL_SIZE);
    assign in_x  = (bg.hcount >= ball_x) && ({1'b0, bg.hcount} < x_end);
    assign in_y  = (bg.vcount >= ball_y) && ({1'b0, bg.vcount} < y_end);

`ifdef DRAW_BALL_ROUND_EN
    localparam logic signed [13:0] DIAM_M1 = 14'(BALL_SIZE - 1);
    localparam logic signed [28:0] RAD2X4  = 29'(BALL_SIZE * BALL_SIZE);

    coord_t             dx;
    coord_t             dy;
    logic signed [13:0] ex;
    logic signed [13:0] ey;
    logic signed [27:0] ex2;
    logic signed [27:0] ey2;
    logic signed [28:0] dist2;

    // Doubled offsets from the ball centre keep the test in integers.
    assign dx      = bg.hcount - ball_x;
    assign dy      = bg.vcount - ball_y;
    assign ex      = $signed({2'b00, dx, 1'b0}) - DIAM_M1;
    assign ey      = $signed({2'b00, dy, 1'b0}) - DIAM_M1;
    assign ex2     = ex * ex;
    assign ey2     = ey * ey;
    assign dist2   = 29'(ex2) + 29'(ey2);
    assign in_disc = (dist2 <= RAD2X4);
`else
    assign in_disc = 1'b1;
`endif

    assign hit = !bg.hblnk && !bg.vblnk && in_x && in_y && in_disc;

    // Stage p1: registered timing and composited colour
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_p1 <= '0;
            vcount_p1 <= '0;
            hsync_p1  <= 1'b0;
            vsync_p1  <= 1'b0;
            hblnk_p1  <= 1'b0;
            vblnk_p1  <= 1'b0;
            rgb_p1    <= RGB_BLACK;
        end else begin
            hcount_p1 <= bg.hcount;
            vcount_p1 <= bg.vcount;
            hsync_p1  <= bg.hsync;
            vsync_p1  <= bg.vsync;
            hblnk_p1  <= bg.hblnk;
            vblnk_p1  <= bg.vblnk;
            rgb_p1    <= hit ? BALL_COLOR : bg.rgb;
        end
    end

    assign disp.hcount = hcount_p1;
    assign disp.vcount = vcount_p1;
    assign disp.hsync  = hsync_p1;
    assign disp.vsync  = vsync_p1;
    assign disp.hblnk  = hblnk_p1;
    assign disp.vblnk  = vblnk_p1;
    assign disp.rgb    = rgb_p1;

endmodule

// File: tb/tb_draw_ball.sv
// Scoreboard bench for draw_ball: directed stimulus queues expectations, a monitor compares them.
module tb_draw_ball;
    import pong_pkg::*;

    logic   pclk = 1'b0;
    logic   rst = 1'b1;
    logic   serve = 1'b0;
    logic   serve_dir = 1'b0;
    logic   bounce_x = 1'b0;
    coord_t ball_x;
    coord_t ball_y;
    logic   miss_left;
    logic   miss_right;

    draw_ball_if bg ();
    draw_ball_if disp ();

    draw_ball dut (
        .pclk       (pclk),
        .rst        (rst),
        .bg         (bg),
        .disp       (disp),
        .serve      (serve),
        .serve_dir  (serve_dir),
        .bounce_x   (bounce_x),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .miss_left  (miss_left),
        .miss_right (miss_right)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    localparam int S_X = 0, S_Y = 1, S_RGB = 2, S_ML = 3, S_MR = 4, S_HC = 5,
                   S_VC = 6, S_HS = 7, S_VS = 8, S_HB = 9, S_VB = 10;

    typedef struct {
        int          due;
        int          sel;
        logic [11:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic drain_chk = 1'b0;

    function automatic logic [11:0] observe(int sel);
        case (sel)
            S_X:     return {1'b0, ball_x};
            S_Y:     return {1'b0, ball_y};
            S_RGB:   return disp.rgb;
            S_ML:    return {11'b0, miss_left};
            S_MR:    return {11'b0, miss_right};
            S_HC:    return {1'b0, disp.hcount};
            S_VC:    return {1'b0, disp.vcount};
            S_HS:    return {11'b0, disp.hsync};
            S_VS:    return {11'b0, disp.vsync};
            S_HB:    return {11'b0, disp.hblnk};
            S_VB:    return {11'b0, disp.vblnk};
            default: return 12'hxxx;
        endcase
    endfunction

    exp_t        cur;
    logic [11:0] act;
    always @(negedge pclk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            act = observe(cur.sel);
            checks++;
            if (act !== cur.val) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h (cycle %0d)", cur.name, act, cur.val, cyc);
            end
        end
        if (drain_chk && sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
            sb.delete();
        end
    end

    task automatic expect_now(int sel, logic [11:0] val, string name);
        sb.push_back('{due: cyc, sel: sel, val: val, name: name});
    endtask

    task automatic expect_next(int sel, logic [11:0] val, string name);
        sb.push_back('{due: cyc + 1, sel: sel, val: val, name: name});
    endtask

    task automatic step(int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // Returns just after the edge on which the frame tick is taken.
    task automatic frame();
        bg.vblnk = 1'b0;
        step(2);
        bg.vblnk = 1'b1;
        step(1);
    endtask

    task automatic frames(int n);
        repeat (n) frame();
    endtask

    task automatic pix(int h, int v, logic hb, logic vb, logic [11:0] rgb,
                       logic [11:0] exp_rgb, string name);
        bg.hcount = 11'(h);
        bg.vcount = 11'(v);
        bg.hblnk  = hb;
        bg.vblnk  = vb;
        bg.rgb    = rgb;
        expect_next(S_RGB, exp_rgb, name);
        step(1);
    endtask

    task automatic do_serve(logic dir);
        serve     = 1'b1;
        serve_dir = dir;
        step(1);
        serve     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bg.hcount = 11'd100;
        bg.vcount = 11'd200;
        bg.hsync  = 1'b1;
        bg.vsync  = 1'b1;
        bg.hblnk  = 1'b1;
        bg.vblnk  = 1'b1;
        bg.rgb    = 12'habc;

        // Reset values
        rst = 1'b1;
        step(3);
        expect_now(S_X, 12'd504, "rst_ball_x");
        expect_now(S_Y, 12'd376, "rst_ball_y");
        expect_now(S_RGB, 12'h000, "rst_rgb_out");
        expect_now(S_ML, 12'd0, "rst_miss_left");
        expect_now(S_MR, 12'd0, "rst_miss_right");
        expect_now(S_HC, 12'd0, "rst_hcount_out");
        expect_now(S_HS, 12'd0, "rst_hsync_out");
        expect_now(S_VB, 12'd0, "rst_vblnk_out");
        rst = 1'b0;
        bg.hsync = 1'b0;
        bg.vsync = 1'b0;
        bg.hblnk = 1'b0;

        // Idle: no movement, square overlay at centre
        frames(3);
        expect_now(S_X, 12'd504, "idle_x");
        expect_now(S_Y, 12'd376, "idle_y");
        pix(504, 383, 1'b0, 1'b0, 12'h123, 12'hfff, "ball_left_col");
        pix(519, 384, 1'b0, 1'b0, 12'h123, 12'hfff, "ball_right_col");
        pix(511, 376, 1'b0, 1'b0, 12'h123, 12'hfff, "ball_top_row");
        pix(512, 391, 1'b0, 1'b0, 12'h123, 12'hfff, "ball_bottom_row");
        pix(503, 383, 1'b0, 1'b0, 12'h123, 12'h123, "left_of_ball");
        pix(520, 384, 1'b0, 1'b0, 12'h123, 12'h123, "right_of_ball");
        pix(511, 375, 1'b0, 1'b0, 12'h123, 12'h123, "above_ball");
        pix(512, 392, 1'b0, 1'b0, 12'h123, 12'h123, "below_ball");
        pix(510, 380, 1'b1, 1'b0, 12'h0f0, 12'h0f0, "hblnk_passthru");
        pix(510, 380, 1'b0, 1'b1, 12'h00f, 12'h00f, "vblnk_passthru");
        pix(100, 100, 1'b0, 1'b0, 12'h456, 12'h456, "far_background");

        // Timing signals lag by exactly one pclk
        for (int i = 0; i < 4; i++) begin
            bg.hcount = 11'(i * 37 + 5);
            bg.vcount = 11'(i * 11 + 2);
            bg.hsync  = 1'((i % 2) == 1);
            bg.vsync  = 1'(((i / 2) % 2) == 1);
            bg.hblnk  = 1'((i % 2) == 0);
            bg.vblnk  = 1'(i == 2);
            bg.rgb    = 12'h000;
            expect_next(S_HC, 12'(i * 37 + 5), "hcount_lag");
            expect_next(S_VC, 12'(i * 11 + 2), "vcount_lag");
            expect_next(S_HS, 12'(i % 2), "hsync_lag");
            expect_next(S_VS, 12'((i / 2) % 2), "vsync_lag");
            expect_next(S_HB, 12'((i + 1) % 2), "hblnk_lag");
            expect_next(S_VB, (i == 2) ? 12'd1 : 12'd0, "vblnk_lag");
            step(1);
        end
        bg.hblnk = 1'b0;

        // Serve right: moves only on ticks
        do_serve(1'b1);
        expect_now(S_X, 12'd504, "serve_no_tick_x");
        frame();
        expect_now(S_X, 12'd508, "move1_x");
        expect_now(S_Y, 12'd380, "move1_y");
        frame();
        expect_now(S_X, 12'd512, "move2_x");
        expect_now(S_Y, 12'd384, "move2_y");

        // Bottom wall bounce
        frames(91);
        expect_now(S_Y, 12'd748, "pre_bottom_y");
        expect_now(S_X, 12'd876, "pre_bottom_x");
        frame();
        expect_now(S_Y, 12'd752, "bottom_clamp_y");
        frame();
        expect_now(S_Y, 12'd748, "after_bounce_y");
        expect_now(S_X, 12'd884, "after_bounce_x");

        // Right edge miss
        frames(30);
        expect_now(S_X, 12'd1004, "pre_miss_x");
        expect_now(S_MR, 12'd0, "pre_miss_right");
        frame();
        expect_now(S_MR, 12'd1, "miss_right_pulse");
        expect_now(S_ML, 12'd0, "miss_right_no_left");
        step(1);
        expect_now(S_MR, 12'd0, "miss_right_cleared");
        expect_now(S_X, 12'd504, "miss_recentre_x");
        expect_now(S_Y, 12'd376, "miss_recentre_y");
        frame();
        expect_now(S_X, 12'd504, "post_miss_idle_x");

        // Paddle bounce at the right edge beats the miss
        do_serve(1'b1);
        frames(125);
        expect_now(S_X, 12'd1004, "bounce_pre_x");
        bounce_x = 1'b1;
        step(1);
        bounce_x = 1'b0;
        frame();
        expect_now(S_X, 12'd1000, "bounce_x_pos");
        expect_now(S_Y, 12'd624, "bounce_y_pos");
        expect_now(S_MR, 12'd0, "bounce_no_miss_right");
        expect_now(S_ML, 12'd0, "bounce_no_miss_left");
        frame();
        expect_now(S_X, 12'd996, "bounce_then_left_x");

        // Reset mid-move
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_now(S_X, 12'd504, "midmove_rst_x");
        expect_now(S_Y, 12'd376, "midmove_rst_y");
        frame();
        expect_now(S_X, 12'd504, "post_rst_idle_x");

        // Left edge miss
        do_serve(1'b0);
        frames(126);
        expect_now(S_X, 12'd0, "left_pre_miss_x");
        expect_now(S_Y, 12'd624, "left_pre_miss_y");
        frame();
        expect_now(S_ML, 12'd1, "miss_left_pulse");
        expect_now(S_MR, 12'd0, "miss_left_no_right");
        step(1);
        expect_now(S_ML, 12'd0, "miss_left_cleared");
        expect_now(S_X, 12'd504, "miss_left_recentre_x");

        step(2);
        drain_chk = 1'b1;
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
